// File: rtl/baud_gen_prog_if.sv
// baud_gen_prog_if: control/tick bundle for the programmable baud generator.
// master drives en/div_int/div_frac/div_load/sync_clr; slave returns ticks and cfg_err.
interface baud_gen_prog_if #(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
);
   logic              en;
   logic [DIV_W-1:0]  div_int;
   logic [FRAC_W-1:0] div_frac;
   logic              div_load;
   logic              sync_clr;
   logic              os_tick;
   logic              mid_tick;
   logic              bit_tick;
   logic              cfg_err;

   modport master (
      output en, div_int, div_frac, div_load, sync_clr,
      input  os_tick, mid_tick, bit_tick, cfg_err
   );

   modport slave (
      input  en, div_int, div_frac, div_load, sync_clr,
      output os_tick, mid_tick, bit_tick, cfg_err
   );
endinterface

// File: rtl/baud_gen_prog.sv
// baud_gen_prog: fractional-N oversample/bit tick generator for a UART.
// Ports: clk, reset_n (async low), bus (slave: en, div_*, div_load, sync_clr -> ticks, cfg_err).
module baud_gen_prog #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OS_RATE      = 16,
   parameter int RST_DIV_INT  = 325,
   parameter int RST_DIV_FRAC = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   baud_gen_prog_if.slave bus
);
   localparam int OS_W = $clog2(OS_RATE);
   localparam logic [OS_W-1:0] LP_OS_LAST = OS_W'(OS_RATE - 1);
   localparam logic [OS_W-1:0] LP_OS_MID  = OS_W'(OS_RATE / 2 - 1);

   logic [DIV_W-1:0]  r_act_int;
   logic [FRAC_W-1:0] r_act_frac;
   logic [DIV_W-1:0]  r_cnt;
   logic [FRAC_W-1:0] r_acc;
   logic              r_ext;
   logic [OS_W-1:0]   r_os_cnt;
   logic              r_os_tick;
   logic              r_mid_tick;
   logic              r_bit_tick;
   logic              r_cfg_err;

   logic [DIV_W-1:0]  w_term_val;
   logic              w_term;
   logic [FRAC_W:0]   w_sum;
   logic              w_load_ok;
   logic              w_load_bad;
   logic              w_clr;

   // Stretched period: act_int clocks, plus one when the last
   // fractional accumulation carried out.
   assign w_term_val = r_act_int - DIV_W'(1) + {{(DIV_W-1){1'b0}}, r_ext};
   assign w_term     = (r_cnt == w_term_val);
   assign w_sum      = {1'b0, r_acc} + {1'b0, r_act_frac};

   assign w_load_ok  = bus.div_load & (bus.div_int >= DIV_W'(2));
   assign w_load_bad = bus.div_load & ~w_load_ok;
   // A rejected load alone leaves counting untouched; a
   // coincident sync_clr still realigns the phase.
   assign w_clr      = bus.sync_clr | w_load_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_act_int  <= DIV_W'(RST_DIV_INT);
         r_act_frac <= FRAC_W'(RST_DIV_FRAC);
         r_cnt      <= '0;
         r_acc      <= '0;
         r_ext      <= 1'b0;
         r_os_cnt   <= '0;
         r_os_tick  <= 1'b0;
         r_mid_tick <= 1'b0;
         r_bit_tick <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_err  <= w_load_bad;
         r_os_tick  <= 1'b0;
         r_mid_tick <= 1'b0;
         r_bit_tick <= 1'b0;
         if (w_clr) begin
            if (w_load_ok) begin
               r_act_int  <= bus.div_int;
               r_act_frac <= bus.div_frac;
            end
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ext    <= 1'b0;
            r_os_cnt <= '0;
         end else if (bus.en) begin
            if (w_term) begin
               r_cnt      <= '0;
               r_acc      <= w_sum[FRAC_W-1:0];
               r_ext      <= w_sum[FRAC_W];
               r_os_cnt   <= r_os_cnt + OS_W'(1);
               r_os_tick  <= 1'b1;
               r_mid_tick <= (r_os_cnt == LP_OS_MID);
               r_bit_tick <= (r_os_cnt == LP_OS_LAST);
            end else begin
               r_cnt <= r_cnt + DIV_W'(1);
            end
         end
      end
   end

   assign bus.os_tick  = r_os_tick;
   assign bus.mid_tick = r_mid_tick;
   assign bus.bit_tick = r_bit_tick;
   assign bus.cfg_err  = r_cfg_err;
endmodule

// File: tb/tb_baud_gen_prog.sv
// tb_baud_gen_prog: directed + random check of baud_gen_prog against a
// closed-form tick-time model (tick n lands n*I + floor((n-1)*F/16) enabled clocks after a clear).
module tb_baud_gen_prog;
   localparam int OS = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   baud_gen_prog_if #(.DIV_W(16), .FRAC_W(4)) bus ();

   baud_gen_prog dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   longint m_int, m_frac, m_e, m_n;
   logic   e_os, e_mid, e_bit, e_err;
   longint cyc = 0;
   longint os_q[$];
   longint bit_q[$];

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint t_of(input longint n);
      return n * m_int + (((n - 1) * m_frac) >> 4);
   endfunction

   task automatic model_reset();
      m_int = 325; m_frac = 8; m_e = 0; m_n = 0;
   endtask

   task automatic model_edge();
      logic ok;
      ok = bus.div_load && (bus.div_int >= 16'd2);
      e_err = bus.div_load && !ok;
      e_os = 1'b0; e_mid = 1'b0; e_bit = 1'b0;
      if (bus.sync_clr || ok) begin
         if (ok) begin
            m_int  = longint'(bus.div_int);
            m_frac = longint'(bus.div_frac);
         end
         m_e = 0; m_n = 0;
      end else if (bus.en) begin
         m_e++;
         if (m_e == t_of(m_n + 1)) begin
            m_n++;
            e_os  = 1'b1;
            e_bit = (m_n % OS) == 0;
            e_mid = (m_n % OS) == OS / 2;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      chk("os_tick", bus.os_tick, e_os);
      chk("mid_tick", bus.mid_tick, e_mid);
      chk("bit_tick", bus.bit_tick, e_bit);
      chk("cfg_err", bus.cfg_err, e_err);
      if (bus.os_tick) os_q.push_back(cyc);
      if (bus.bit_tick) bit_q.push_back(cyc);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input int di, input int df);
      bus.div_int  = 16'(di);
      bus.div_frac = 4'(df);
      bus.div_load = 1'b1;
      step();
      bus.div_load = 1'b0;
   endtask

   initial begin
      longint l0, k;
      bus.en = 1'b0; bus.div_int = '0; bus.div_frac = '0;
      bus.div_load = 1'b0; bus.sync_clr = 1'b0;
      model_reset();
      #12;
      chk("rst_os", bus.os_tick, 1'b0);
      chk("rst_mid", bus.mid_tick, 1'b0);
      chk("rst_bit", bus.bit_tick, 1'b0);
      chk("rst_err", bus.cfg_err, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.en = 1'b1;
      run(10);

      // integer divisor 4
      load(4, 0);
      l0 = cyc; os_q.delete(); bit_q.delete();
      run(140);
      chk_v("div4_first_os", (os_q.size() > 0) ? os_q[0] - l0 : -1, 4);
      chk_v("div4_os_gap", (os_q.size() > 1) ? os_q[1] - os_q[0] : -1, 4);
      chk_v("div4_first_bit", (bit_q.size() > 0) ? bit_q[0] - l0 : -1, 64);
      chk_v("div4_bit_gap",
            (bit_q.size() > 1) ? bit_q[1] - bit_q[0] : -1, 64);

      // fractional divisor 4 + 8/16
      load(4, 8);
      os_q.delete();
      run(160);
      chk_v("frac_span32",
            (os_q.size() > 32) ? os_q[32] - os_q[0] : -1, 144);

      // rejected load keeps previous divisor and phase
      load(4, 0);
      run(10);
      load(1, 3);
      run(20);

      // sync_clr at cnt=2
      load(4, 0);
      run(2);
      bus.sync_clr = 1'b1;
      step();
      bus.sync_clr = 1'b0;
      run(70);

      // en low mid-period
      run(2);
      bus.en = 1'b0;
      run(10);
      bus.en = 1'b1;
      run(20);

      // rejected load coincident with sync_clr
      bus.sync_clr = 1'b1;
      load(0, 5);
      bus.sync_clr = 1'b0;
      run(10);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bus.en       = ($urandom_range(0, 9) != 0);
         bus.div_load = ($urandom_range(0, 59) == 0);
         bus.div_int  = 16'($urandom_range(0, 6));
         bus.div_frac = 4'($urandom);
         bus.sync_clr = ($urandom_range(0, 79) == 0);
         step();
      end
      bus.en = 1'b1; bus.div_load = 1'b0; bus.sync_clr = 1'b0;

      // async reset mid-bit, while a tick is high
      load(4, 0);
      run(40);
      for (int i = 0; i < 8 && !bus.os_tick; i++) step();
      chk("pre_rst_os_high", bus.os_tick, 1'b1);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst_os", bus.os_tick, 1'b0);
      chk("arst_mid", bus.mid_tick, 1'b0);
      chk("arst_bit", bus.bit_tick, 1'b0);
      chk("arst_err", bus.cfg_err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      k = -1;
      for (int i = 1; i <= 400; i++) begin
         step();
         if (bus.os_tick) begin
            k = i;
            break;
         end
      end
      chk_v("rst_first_os", k, 325);
      run(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
